req_arbiter_8: RTL and testbench

//  Sequential arbiter that shares one downstream resource between 8 requesters.

---
 rtl/req_arbiter_8.sv | 112 +++++++++++
 tb/tb_req_arbiter_8.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/req_arbiter_8.sv
// Eight-way request arbiter with fixed-priority or round-robin selection.
// The grant is registered and held while its owner keeps requesting; MAX_HOLD bounds the hold time.
module req_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       rr_mode,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid,
   output logic       hold_timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         HOLD_EN  = (MAX_HOLD != 0);

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [2:0] last_id, last_id_nxt;
   logic [2:0] id_nxt;
   logic       valid_nxt, timeout_nxt;
   logic [7:0] grant_nxt, masked;

   // Round-robin search visits last+8 (== last) first and last+1 last, so the
   // lowest offset past the previous winner ends up overriding the rest.
   function automatic logic [2:0] pick(input logic [7:0] m, input logic rr,
                                       input logic [2:0] last);
      logic [2:0] win;
      logic [2:0] idx;
      win = '0;
      if (rr) begin
         for (int unsigned k = 8; k >= 1; k--) begin
            idx = last + 3'(k);
            if (m[idx]) win = idx;
         end
      end else begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (m[i]) win = 3'(i);
         end
      end
      return win;
   endfunction

   always_comb begin
      state_nxt    = state;
      id_nxt       = grant_id;
      valid_nxt    = grant_valid;
      timeout_nxt  = 1'b0;
      hold_cnt_nxt = hold_cnt;
      last_id_nxt  = last_id;
      masked       = req & ~grant;
      case (state)
         IDLE: begin
            if (|req) begin
               id_nxt       = pick(req, rr_mode, last_id);
               valid_nxt    = 1'b1;
               hold_cnt_nxt = 8'd1;
               last_id_nxt  = id_nxt;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            if (!req[grant_id]) begin
               if (|req) begin
                  id_nxt       = pick(req, rr_mode, last_id);
                  hold_cnt_nxt = 8'd1;
                  last_id_nxt  = id_nxt;
               end else begin
                  id_nxt       = '0;
                  valid_nxt    = 1'b0;
                  hold_cnt_nxt = '0;
                  state_nxt    = IDLE;
               end
            end else if (HOLD_EN && (hold_cnt == HOLD_LIM)) begin
               timeout_nxt = 1'b1;
               if (|masked) id_nxt = pick(masked, rr_mode, last_id);
               hold_cnt_nxt = 8'd1;
               last_id_nxt  = id_nxt;
            end else if (hold_cnt != '1) begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      grant_nxt = valid_nxt ? (8'd1 << id_nxt) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         grant_id     <= '0;
         grant_valid  <= 1'b0;
         hold_timeout <= 1'b0;
         hold_cnt     <= '0;
         last_id      <= 3'd7;
      end else begin
         state        <= state_nxt;
         grant        <= grant_nxt;
         grant_id     <= id_nxt;
         grant_valid  <= valid_nxt;
         hold_timeout <= timeout_nxt;
         hold_cnt     <= hold_cnt_nxt;
         last_id      <= last_id_nxt;
      end
   end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8 (MAX_HOLD=4) with hand-computed expected outputs.
module tb_req_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       rr_mode;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       hold_timeout;

   int unsigned n_total;
   int unsigned n_pass;

   req_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .rr_mode      (rr_mode),
      .grant        (grant),
      .grant_id     (grant_id),
      .grant_valid  (grant_valid),
      .hold_timeout (hold_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h (grant,id,valid,timeout packed)", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                             input logic v, input logic to);
      chk(tag, {3'b000, grant, grant_id, grant_valid, hold_timeout},
               {3'b000, g, id, v, to});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b1;
      req     = '0;
      rr_mode = 1'b0;

      // 1. reset state and first grant in each mode
      #2 rst_n = 1'b0;
      #1 expect_out("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'hFF;
      step();
      expect_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      expect_out("fixed_first", 8'h80, 3'd7, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1 expect_out("rst_again", 8'h00, 3'd0, 1'b0, 1'b0);
      rr_mode = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      expect_out("rr_first", 8'h01, 3'd0, 1'b1, 1'b0);

      // 2. fixed priority with release handover and return to idle
      rr_mode = 1'b0;
      req = 8'b0100_0100;
      step();
      expect_out("fixed_6", 8'h40, 3'd6, 1'b1, 1'b0);
      req = 8'b0000_0100;
      step();
      expect_out("fixed_2", 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'h00;
      step();
      expect_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("idle_stay", 8'h00, 3'd0, 1'b0, 1'b0);

      // 3. round-robin rotation forced by the hold limit
      rst_n = 1'b0;
      rr_mode = 1'b1;
      req = 8'hFF;
      step();
      rst_n = 1'b1;
      for (int unsigned k = 0; k < 9; k++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            logic [2:0] eid;
            eid = 3'(k % 8);
            step();
            expect_out($sformatf("rr_rot_k%0d_c%0d", k, c), 8'h01 << eid, eid, 1'b1,
                       (c == 0) && (k > 0));
         end
      end

      // 4. lone requester keeps its grant across timeouts
      req = 8'h08;
      step();
      expect_out("single_take", 8'h08, 3'd3, 1'b1, 1'b0);
      for (int unsigned j = 1; j <= 12; j++) begin
         step();
         expect_out($sformatf("single_j%0d", j), 8'h08, 3'd3, 1'b1, (j % 4) == 0);
      end

      // 5. mode changes take effect only at the next arbitration
      req = 8'h00;
      step();
      expect_out("idle_pre_mode", 8'h00, 3'd0, 1'b0, 1'b0);
      rr_mode = 1'b0;
      req = 8'b0001_0010;
      step();
      expect_out("mode_fixed_4", 8'h10, 3'd4, 1'b1, 1'b0);
      rr_mode = 1'b1;
      step();
      expect_out("mode_held_4", 8'h10, 3'd4, 1'b1, 1'b0);
      req = 8'b0000_0011;
      step();
      expect_out("mode_rr_0", 8'h01, 3'd0, 1'b1, 1'b0);
      rr_mode = 1'b0;
      step();
      expect_out("mode_held_0", 8'h01, 3'd0, 1'b1, 1'b0);
      req = 8'b0000_0110;
      step();
      expect_out("mode_fixed_2", 8'h04, 3'd2, 1'b1, 1'b0);

      // 6. asynchronous reset in the middle of a grant
      req = 8'h20;
      step();
      expect_out("pre_async_5", 8'h20, 3'd5, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 expect_out("async_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      rr_mode = 1'b1;
      req = 8'hFF;
      step();
      expect_out("async_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      expect_out("async_rr_0", 8'h01, 3'd0, 1'b1, 1'b0);
      step();
      expect_out("async_rr_hold", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
